// File: rtl/nfc_pkg.sv
// Shared definitions for the NFC interrupt conditioning path: FSM state
// encoding, default timing constants and interrupt polarity constants that
// the NFC top level uses when it instantiates nfc_irq_cond.
package nfc_pkg;

    // Delivery FSM states for the Pi-side interrupt.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        HOLD   = 2'd2,
        GAP    = 2'd3
    } irq_state_e;

    // Default timing, in clk cycles.
    localparam int DEF_FILT_CYC   = 4;
    localparam int DEF_MIN_ASSERT = 8;
    localparam int DEF_MIN_GAP    = 4;
    localparam int DEF_CNT_W      = 8;

    // Raw NFC controller interrupt polarity choices.
    localparam bit NFC_IRQ_ACT_HIGH = 1'b1;
    localparam bit NFC_IRQ_ACT_LOW  = 1'b0;

    // Larger of two integers, used to size the shared FSM timer.
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter width able to hold 0..v-1, never less than one bit.
    function automatic int cnt_width(input int v);
        return (v > 2) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/nfc_sync_filter.sv
// Input conditioning stage: 2-FF synchronizer, polarity adjust to
// active-high, optional FILT_CYC-sample stability filter, and a one-cycle
// pulse on every inactive->active transition of the conditioned level.
// With USE_FILTER=0 the filter is skipped and the edge detector looks at the
// synchronized sample directly (used for the Pi acknowledge input).
module nfc_sync_filter
    import nfc_pkg::*;
#(
    parameter bit ACT_HIGH   = 1'b1,
    parameter int FILT_CYC   = DEF_FILT_CYC,
    parameter bit USE_FILTER = 1'b1
) (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic rise
);

    // Raw level that means "not active"; synchronizers preset to it so that
    // leaving reset never looks like an edge.
    localparam logic RAW_IDLE = ACT_HIGH ? 1'b0 : 1'b1;

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic sample;
    logic cur;
    logic prev_q, prev_d;

    // Synchronizer next-state: plain two-stage shift.
    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
    end

    // Synchronizer flops, preset to the inactive raw level.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= RAW_IDLE;
            sync2_q <= RAW_IDLE;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    // 1 = active regardless of the raw polarity.
    assign sample = sync2_q ^ RAW_IDLE;

    if (USE_FILTER) begin : g_filter
        localparam int CW = cnt_width(FILT_CYC);
        localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYC - 1);

        logic          filt_q, filt_d;
        logic [CW-1:0] cnt_q, cnt_d;

        // Count consecutive samples disagreeing with the filtered level;
        // flip the level once FILT_CYC of them have been seen in a row.
        always_comb begin
            filt_d = filt_q;
            cnt_d  = '0;
            if (sample != filt_q) begin
                if (cnt_q == CNT_LAST) begin
                    filt_d = ~filt_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end

        // Filter state flops; filtered level starts inactive.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                filt_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                filt_q <= filt_d;
                cnt_q  <= cnt_d;
            end
        end

        assign cur = filt_q;
    end else begin : g_no_filter
        assign cur = sample;
    end

    // Edge detector history: previous conditioned level.
    always_comb begin
        prev_d = cur;
    end

    // History flop for the rising-edge pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = cur & ~prev_q;

endmodule

// File: rtl/nfc_irq_cond.sv
// Conditions the raw NFC controller interrupt into a clean, active-high,
// registered Pi interrupt with a guaranteed minimum high time and minimum
// low gap. Pulse mode drops pi_irq after MIN_ASSERT cycles; latched mode
// holds it until the Pi acknowledges with a rising edge on pi_irq_ack.
// One event can queue behind the current assertion (irq_pending); further
// events while one is queued set the sticky irq_missed flag.
// Optional macro NFC_IRQ_COUNT_EN adds the irq_count filtered-event counter.
module nfc_irq_cond
    import nfc_pkg::*;
#(
    parameter bit IRQ_ACT_HIGH = NFC_IRQ_ACT_HIGH,
    parameter int FILT_CYC     = DEF_FILT_CYC,
    parameter int MIN_ASSERT   = DEF_MIN_ASSERT,
    parameter int MIN_GAP      = DEF_MIN_GAP,
    parameter bit LATCH_MODE   = 1'b0,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             nfc_irq,
    input  logic             pi_irq_ack,
    output logic             pi_irq,
    output logic             irq_pending,
    output logic             irq_missed
`ifdef NFC_IRQ_COUNT_EN
    ,
    output logic [CNT_W-1:0] irq_count
`endif
);

    localparam int TW = cnt_width(max2(MIN_ASSERT, MIN_GAP));
    localparam logic [TW-1:0] ASSERT_LAST = TW'(MIN_ASSERT - 1);
    localparam logic [TW-1:0] GAP_LAST    = TW'(MIN_GAP - 1);

    // Reject parameter sets the timing logic cannot honour.
    if (FILT_CYC < 1 || MIN_ASSERT < 1 || MIN_GAP < 1 || CNT_W < 1) begin : g_bad_param
        $error("nfc_irq_cond: FILT_CYC, MIN_ASSERT, MIN_GAP and CNT_W must all be >= 1");
    end

    logic irq_event;
    logic ack_event;

    irq_state_e    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          pi_irq_q, pi_irq_d;
    logic          pending_q, pending_d;
    logic          missed_q, missed_d;
    logic          gap_exit;

    // Filtered interrupt path: one pulse per qualified assertion.
    nfc_sync_filter #(
        .ACT_HIGH   (IRQ_ACT_HIGH),
        .FILT_CYC   (FILT_CYC),
        .USE_FILTER (1'b1)
    ) u_irq_filt (
        .clk    (clk),
        .resetn (resetn),
        .din    (nfc_irq),
        .rise   (irq_event)
    );

    // Acknowledge path: synchronizer and edge detect only, no filtering.
    nfc_sync_filter #(
        .ACT_HIGH   (1'b1),
        .FILT_CYC   (1),
        .USE_FILTER (1'b0)
    ) u_ack_sync (
        .clk    (clk),
        .resetn (resetn),
        .din    (pi_irq_ack),
        .rise   (ack_event)
    );

    assign gap_exit = (state_q == GAP) && (timer_q == GAP_LAST);

    // Delivery FSM next state, shared timer, pending/missed bookkeeping.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        pending_d = pending_q;
        missed_d  = missed_q;

        case (state_q)
            IDLE: begin
                if (irq_event) begin
                    state_d = ASSERT;
                    timer_d = '0;
                end
            end
            ASSERT: begin
                if (timer_q == ASSERT_LAST) begin
                    state_d = LATCH_MODE ? HOLD : GAP;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            HOLD: begin
                if (ack_event) begin
                    state_d  = GAP;
                    timer_d  = '0;
                    missed_d = 1'b0;
                end
            end
            GAP: begin
                if (timer_q == GAP_LAST) begin
                    // An event landing on the exit cycle itself re-asserts
                    // directly rather than being parked as pending in IDLE.
                    if (pending_q || irq_event) begin
                        state_d = ASSERT;
                        timer_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase

        // Events outside IDLE queue one deep; a second queued event is
        // recorded as missed. The GAP exit consumes whatever was queued.
        if (irq_event && (state_q != IDLE)) begin
            if (pending_q) begin
                missed_d = 1'b1;
            end
            pending_d = gap_exit ? 1'b0 : 1'b1;
        end else if (gap_exit) begin
            pending_d = 1'b0;
        end

        // pi_irq follows the next state so it comes straight from a flop.
        pi_irq_d = (state_d == ASSERT) || (state_d == HOLD);
    end

    // Delivery FSM and status flops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            pi_irq_q  <= 1'b0;
            pending_q <= 1'b0;
            missed_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pi_irq_q  <= pi_irq_d;
            pending_q <= pending_d;
            missed_q  <= missed_d;
        end
    end

    assign pi_irq      = pi_irq_q;
    assign irq_pending = pending_q;
    assign irq_missed  = missed_q;

`ifdef NFC_IRQ_COUNT_EN
    logic [CNT_W-1:0] count_q, count_d;

    // Count every filtered event, including missed ones; wraps naturally.
    always_comb begin
        count_d = irq_event ? (count_q + CNT_W'(1)) : count_q;
    end

    // Event counter flop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign irq_count = count_q;
`endif

endmodule
